period_meter: RTL

Measures an incoming slow square wave, such as the divided clock that drives the 8-bit counter, in units of the fast system clock. It synchronises the asynchronous input and detects its edges. Each full cycle produces one period count and one high-time count, qualified by a single-cycle strobe. A missing input is flagged by a timeout. It sits in the `clk` domain beside the counter/SSD logic and serves as the self-check and readout for slow-clock generation.

---
 rtl/period_meter_pkg.sv | 13 +
 rtl/sync_edge_detect.sv | 33 +++
 rtl/period_meter.sv | 109 ++++++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and default constants for the slow-clock period meter.
package period_meter_pkg;

  typedef enum logic [0:0] {
    StArm,
    StMeasure
  } state_e;

  localparam int unsigned DefCntW       = 32;
  localparam int unsigned DefTimeout    = 200_000_000;
  localparam int unsigned DefSyncStages = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous level into clk and emits one-cycle rise/fall pulses.
module sync_edge_detect
  import period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delayed_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      delayed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
      delayed_q <= synced;
    end
  end

  assign rise = synced & ~delayed_q;
  assign fall = ~synced & delayed_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles, with
// a no-signal timeout when rising edges stop arriving.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned TIMEOUT     = DefTimeout,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cycles,
  output logic             meas_valid,
  output logic             no_signal
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .rise     (rise),
    .fall     (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_lat_q, high_lat_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             no_sig_q, no_sig_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;

  assign cnt_inc = cnt_q + CNT_W'(1);
  // A rise in the same cycle as the terminal count takes priority.
  assign timeout = (cnt_q == TimeoutLast) && !rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StArm;
      cnt_q      <= '0;
      high_lat_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      no_sig_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_lat_q <= high_lat_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      no_sig_q   <= no_sig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = StArm;
    end else begin
      unique case (state_q)
        StArm:     if (rise) state_d = StMeasure;
        StMeasure: state_d = StMeasure;
        default:   state_d = StArm;
      endcase
    end
  end

  always_comb begin
    cnt_d      = rise ? '0 : cnt_inc;
    high_lat_d = high_lat_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    no_sig_d   = no_sig_q;
    if (timeout) begin
      cnt_d    = '0;
      period_d = '0;
      high_d   = '0;
      no_sig_d = 1'b1;
    end else if (state_q == StMeasure) begin
      if (fall) high_lat_d = cnt_inc;
      if (rise) begin
        period_d = cnt_inc;
        high_d   = high_lat_q;
        valid_d  = 1'b1;
        no_sig_d = 1'b0;
      end
    end
  end

  assign period      = period_q;
  assign high_cycles = high_q;
  assign meas_valid  = valid_q;
  assign no_signal   = no_sig_q;

endmodule
